naneye_rx_decoder: RTL and testbench

NANEYE_RX_DECODER -- requirements
Module: naneye_rx_decoder

---
 rtl/naneye_pkg.sv | 19 +
 rtl/naneye_runlen.sv | 97 +++++++++
 rtl/naneye_rx_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_naneye_rx_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/naneye_pkg.sv
// rtl/naneye_pkg.sv - shared state encoding and default thresholds for the NanEye receive decoder
package naneye_pkg;

    // One-hot decoder states
    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_SYNC     = 5'b00010,
        ST_DECODE   = 5'b00100,
        ST_EOF      = 5'b01000,
        ST_UPSTREAM = 5'b10000
    } state_t;

    // Default configuration values for the CFG_* inputs
    localparam int DEF_HF_BIT   = 8;
    localparam int DEF_FL_BIT   = 17;
    localparam int DEF_SYNC_CNT = 6060;
    localparam int DEF_EOF_CNT  = 153;

endpackage

// File: rtl/naneye_runlen.sv
// rtl/naneye_runlen.sv - IDDR pair pipeline, run-length accumulator and half/full period classifier
module naneye_runlen
    import naneye_pkg::*;
#(
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_h,
    input  logic             din_l,
    input  logic [LEN_W-1:0] cfg_hf_bit,
    input  logic [LEN_W-1:0] cfg_fl_bit,
    output logic             trans_o,
    output logic             full_o,
    output logic             half_o,
    output logic             long_zero_o
);

    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic             prev_lsb_q, prev_lsb_d;
    logic [LEN_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             tvld_q, tvld_d;
    logic             lz_q, lz_d;

    logic             mixed;
    logic             const_tr;
    logic [LEN_W:0]   sum1;
    logic [LEN_W:0]   sum2;
    logic [LEN_W-1:0] acc_p1;
    logic [LEN_W-1:0] acc_p2;

    // Next-state: pair pipeline, run-length accumulation, transition latch and long-zero detect
    always_comb begin
        s1_d       = {din_h, din_l};
        s2_d       = s1_q;
        prev_lsb_d = s2_q[0];

        // A mixed pair has its edge mid-pair; a constant pair only marks an edge if it differs from the last sample
        mixed    = s2_q[1] ^ s2_q[0];
        const_tr = !mixed && (s2_q[0] != prev_lsb_q);

        sum1   = {1'b0, acc_q} + (LEN_W+1)'(1);
        sum2   = {1'b0, acc_q} + (LEN_W+1)'(2);
        acc_p1 = sum1[LEN_W] ? '1 : sum1[LEN_W-1:0];
        acc_p2 = sum2[LEN_W] ? '1 : sum2[LEN_W-1:0];

        acc_d  = acc_p2;
        len_d  = len_q;
        tvld_d = 1'b0;
        if (mixed) begin
            acc_d  = LEN_W'(1);
            len_d  = acc_p1;
            tvld_d = !lz_q;
        end else if (const_tr) begin
            acc_d  = LEN_W'(2);
            len_d  = acc_q;
            tvld_d = !lz_q;
        end

        lz_d = lz_q;
        if (s2_q != 2'b00) begin
            lz_d = 1'b0;
        end else if (acc_q > cfg_fl_bit) begin
            lz_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 2'b00;
            s2_q       <= 2'b00;
            prev_lsb_q <= 1'b0;
            acc_q      <= '0;
            len_q      <= '0;
            tvld_q     <= 1'b0;
            lz_q       <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_lsb_q <= prev_lsb_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            tvld_q     <= tvld_d;
            lz_q       <= lz_d;
        end
    end

    // Compare stage uses the live threshold so configuration changes apply on the next edge
    assign trans_o     = tvld_q;
    assign full_o      = tvld_q && (len_q > cfg_hf_bit);
    assign half_o      = tvld_q && !(len_q > cfg_hf_bit);
    assign long_zero_o = lz_q;

endmodule

// File: rtl/naneye_rx_decoder.sv
// rtl/naneye_rx_decoder.sv - NanEye line decoder: frame FSM, bit recovery and word deserialiser
module naneye_rx_decoder
    import naneye_pkg::*;
#(
    parameter int LEN_W  = 6,
    parameter int WORD_W = 12,
    parameter int SYNC_W = 13,
    parameter int ERR_W  = 16
) (
    input  logic              SCLOCK,
    input  logic              RESET,
    input  logic              DIN_H,
    input  logic              DIN_L,
    input  logic              ENABLE,
    input  logic [LEN_W-1:0]  CFG_HF_BIT,
    input  logic [LEN_W-1:0]  CFG_FL_BIT,
    input  logic [SYNC_W-1:0] CFG_SYNC_CNT,
    input  logic [7:0]        CFG_EOF_CNT,
    output logic [WORD_W-1:0] WORD_DATA,
    output logic              WORD_VALID,
    output logic              FRAME_START,
    output logic              FRAME_END,
    output logic              FRAME_ACTIVE,
    output logic              BIT_ERROR,
    output logic [ERR_W-1:0]  ERR_CNT
);

    localparam int BC_W = $clog2(WORD_W + 1);

    logic trans, full, half, long_zero;

    naneye_runlen #(.LEN_W(LEN_W)) u_runlen (
        .clk         (SCLOCK),
        .rst_n       (RESET),
        .din_h       (DIN_H),
        .din_l       (DIN_L),
        .cfg_hf_bit  (CFG_HF_BIT),
        .cfg_fl_bit  (CFG_FL_BIT),
        .trans_o     (trans),
        .full_o      (full),
        .half_o      (half),
        .long_zero_o (long_zero)
    );

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] cnt_q, cnt_d;
    logic              lz_prev_q, lz_prev_d;
    logic              half_flag_q, half_flag_d;
    logic              level_q, level_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_end_q, frame_end_d;
    logic              frame_active_q, frame_active_d;
    logic              bit_error_q, bit_error_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              lz_fall, lz_rise;
    logic              emit, ebit;
    logic [WORD_W-1:0] shifted;

    // Frame FSM, bit recovery and word assembly
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lz_prev_d      = long_zero;
        half_flag_d    = half_flag_q;
        level_d        = level_q;
        sh_d           = sh_q;
        bc_d           = bc_q;
        word_data_d    = word_data_q;
        word_valid_d   = 1'b0;
        frame_start_d  = 1'b0;
        frame_end_d    = 1'b0;
        bit_error_d    = 1'b0;
        err_cnt_d      = err_cnt_q;
        emit           = 1'b0;
        ebit           = 1'b0;
        shifted        = '0;

        lz_fall = lz_prev_q && !long_zero;
        lz_rise = !lz_prev_q && long_zero;

        case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                half_flag_d = 1'b0;
                level_d     = 1'b0;
                sh_d        = '0;
                bc_d        = '0;
                if (lz_fall) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (lz_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (trans) begin
                    if (cnt_q + SYNC_W'(1) == CFG_SYNC_CNT) begin
                        state_d       = ST_DECODE;
                        cnt_d         = '0;
                        frame_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + SYNC_W'(1);
                    end
                end
            end
            ST_DECODE: begin
                if (full) begin
                    if (half_flag_q) begin
                        // A full period cannot follow an unpaired half period
                        bit_error_d = 1'b1;
                        half_flag_d = 1'b0;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end else begin
                        level_d = !level_q;
                        emit    = 1'b1;
                        ebit    = !level_q;
                    end
                end else if (half) begin
                    half_flag_d = !half_flag_q;
                    if (half_flag_q) begin
                        emit = 1'b1;
                        ebit = level_q;
                    end
                end
                if (emit) begin
                    shifted = {sh_q[WORD_W-2:0], ebit};
                    if (bc_q == BC_W'(WORD_W - 1)) begin
                        word_data_d  = shifted;
                        word_valid_d = 1'b1;
                        sh_d         = '0;
                        bc_d         = '0;
                    end else begin
                        sh_d = shifted;
                        bc_d = bc_q + BC_W'(1);
                    end
                end
                // A completed word above is still published; only a partial word is dropped here
                if (lz_rise) begin
                    state_d     = ST_EOF;
                    cnt_d       = '0;
                    sh_d        = '0;
                    bc_d        = '0;
                    half_flag_d = 1'b0;
                    level_d     = 1'b0;
                end
            end
            ST_EOF: begin
                if (cnt_q + SYNC_W'(1) >= SYNC_W'(CFG_EOF_CNT)) begin
                    state_d     = ST_UPSTREAM;
                    cnt_d       = '0;
                    frame_end_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + SYNC_W'(1);
                end
            end
            ST_UPSTREAM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable abandons everything except the error history
        if (!ENABLE) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            half_flag_d   = 1'b0;
            level_d       = 1'b0;
            sh_d          = '0;
            bc_d          = '0;
            word_data_d   = '0;
            word_valid_d  = 1'b0;
            frame_start_d = 1'b0;
            frame_end_d   = 1'b0;
            bit_error_d   = 1'b0;
            err_cnt_d     = err_cnt_q;
        end

        frame_active_d = (state_d == ST_DECODE);
    end

    // State and registered outputs
    always_ff @(posedge SCLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            lz_prev_q      <= 1'b0;
            half_flag_q    <= 1'b0;
            level_q        <= 1'b0;
            sh_q           <= '0;
            bc_q           <= '0;
            word_data_q    <= '0;
            word_valid_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_active_q <= 1'b0;
            bit_error_q    <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lz_prev_q      <= lz_prev_d;
            half_flag_q    <= half_flag_d;
            level_q        <= level_d;
            sh_q           <= sh_d;
            bc_q           <= bc_d;
            word_data_q    <= word_data_d;
            word_valid_q   <= word_valid_d;
            frame_start_q  <= frame_start_d;
            frame_end_q    <= frame_end_d;
            frame_active_q <= frame_active_d;
            bit_error_q    <= bit_error_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign WORD_DATA    = word_data_q;
    assign WORD_VALID   = word_valid_q;
    assign FRAME_START  = frame_start_q;
    assign FRAME_END    = frame_end_q;
    assign FRAME_ACTIVE = frame_active_q;
    assign BIT_ERROR    = bit_error_q;
    assign ERR_CNT      = err_cnt_q;

endmodule

// File: tb/tb_naneye_rx_decoder.sv
// tb/tb_naneye_rx_decoder.sv - scoreboard bench for naneye_rx_decoder
module tb_naneye_rx_decoder;
    import naneye_pkg::*;

    localparam int LEN_W  = 6;
    localparam int WORD_W = 12;
    localparam int SYNC_W = 13;
    localparam int ERR_W  = 8;

    logic              SCLOCK = 1'b0;
    logic              RESET;
    logic              DIN_H;
    logic              DIN_L;
    logic              ENABLE;
    logic [LEN_W-1:0]  CFG_HF_BIT;
    logic [LEN_W-1:0]  CFG_FL_BIT;
    logic [SYNC_W-1:0] CFG_SYNC_CNT;
    logic [7:0]        CFG_EOF_CNT;
    logic [WORD_W-1:0] WORD_DATA;
    logic              WORD_VALID;
    logic              FRAME_START;
    logic              FRAME_END;
    logic              FRAME_ACTIVE;
    logic              BIT_ERROR;
    logic [ERR_W-1:0]  ERR_CNT;

    naneye_rx_decoder #(
        .LEN_W (LEN_W),
        .WORD_W(WORD_W),
        .SYNC_W(SYNC_W),
        .ERR_W (ERR_W)
    ) dut (
        .SCLOCK      (SCLOCK),
        .RESET       (RESET),
        .DIN_H       (DIN_H),
        .DIN_L       (DIN_L),
        .ENABLE      (ENABLE),
        .CFG_HF_BIT  (CFG_HF_BIT),
        .CFG_FL_BIT  (CFG_FL_BIT),
        .CFG_SYNC_CNT(CFG_SYNC_CNT),
        .CFG_EOF_CNT (CFG_EOF_CNT),
        .WORD_DATA   (WORD_DATA),
        .WORD_VALID  (WORD_VALID),
        .FRAME_START (FRAME_START),
        .FRAME_END   (FRAME_END),
        .FRAME_ACTIVE(FRAME_ACTIVE),
        .BIT_ERROR   (BIT_ERROR),
        .ERR_CNT     (ERR_CNT)
    );

    always #5 SCLOCK = ~SCLOCK;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    bit                line_q[$];
    bit                cur_level = 1'b0;
    logic [WORD_W-1:0] exp_word[$];
    logic [ERR_W-1:0]  exp_err[$];
    logic [ERR_W-1:0]  err_model = '0;

    int   fs_cnt   = 0;
    int   fe_cnt   = 0;
    int   word_cnt = 0;
    int   err_seen = 0;
    int   fall_cyc = 0;
    logic prev_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One line run of the given length in half-clock samples; each run flips the line level
    task automatic run_h(input int halves);
        cur_level = ~cur_level;
        repeat (halves) line_q.push_back(cur_level);
    endtask

    task automatic sync_preamble(input int n, input int halves);
        run_h(4);
        repeat (n - 1) run_h(halves);
    endtask

    task automatic push_error();
        err_model = (err_model == '1) ? err_model : err_model + ERR_W'(1);
        exp_err.push_back(err_model);
        run_h(8);
        run_h(9);
    endtask

    task automatic wait_fe(input int target, input int limit);
        int n = 0;
        while (fe_cnt < target && n < limit) begin
            @(negedge SCLOCK);
            n++;
        end
        check("wait_frame_end", fe_cnt, target);
    endtask

    task automatic wait_active(input int limit);
        int n = 0;
        while (!FRAME_ACTIVE && n < limit) begin
            @(negedge SCLOCK);
            n++;
        end
        check("wait_frame_active", FRAME_ACTIVE, 1);
    endtask

    // Line driver: two half-clock samples per cycle, older sample on DIN_H; idle line is low
    initial begin
        DIN_H = 1'b0;
        DIN_L = 1'b0;
        forever begin
            @(negedge SCLOCK);
            DIN_H = (line_q.size() > 0) ? line_q.pop_front() : 1'b0;
            DIN_L = (line_q.size() > 0) ? line_q.pop_front() : 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    initial begin
        forever begin
            @(negedge SCLOCK);
            cyc++;
            if (WORD_VALID) begin
                word_cnt++;
                if (exp_word.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL word_unexpected: got %0h, no word expected", WORD_DATA);
                end else begin
                    check("word_data", WORD_DATA, exp_word.pop_front());
                end
            end
            if (BIT_ERROR) begin
                err_seen++;
                if (exp_err.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL bit_error_unexpected: err_cnt %0d, no error expected", ERR_CNT);
                end else begin
                    check("err_cnt_at_error", ERR_CNT, exp_err.pop_front());
                end
            end
            if (FRAME_START) begin
                fs_cnt++;
                check("frame_active_at_start", FRAME_ACTIVE, 1);
            end
            if (prev_active && !FRAME_ACTIVE) fall_cyc = cyc;
            if (FRAME_END) begin
                fe_cnt++;
                check("eof_hold_cycles", cyc - fall_cyc, DEF_EOF_CNT);
            end
            prev_active = FRAME_ACTIVE;
        end
    end

    initial begin
        int w1[12] = '{9, 10, 11, 12, 9, 10, 11, 12, 9, 10, 11, 12};
        int w2[15] = '{10, 3, 8, 11, 9, 4, 5, 6, 7, 12, 10, 9, 11, 10, 9};
        int pw[6]  = '{10, 2, 2, 9, 11, 12};

        RESET        = 1'b0;
        ENABLE       = 1'b1;
        CFG_HF_BIT   = LEN_W'(DEF_HF_BIT);
        CFG_FL_BIT   = LEN_W'(DEF_FL_BIT);
        CFG_SYNC_CNT = SYNC_W'(DEF_SYNC_CNT);
        CFG_EOF_CNT  = 8'(DEF_EOF_CNT);
        repeat (3) @(negedge SCLOCK);
        check("reset_word_data", WORD_DATA, 0);
        check("reset_word_valid", WORD_VALID, 0);
        check("reset_frame_start", FRAME_START, 0);
        check("reset_frame_end", FRAME_END, 0);
        check("reset_frame_active", FRAME_ACTIVE, 0);
        check("reset_bit_error", BIT_ERROR, 0);
        check("reset_err_cnt", ERR_CNT, 0);
        RESET = 1'b1;
        repeat (30) @(negedge SCLOCK);

        // Frame 1: default sync, two words, one error, a discarded partial word
        sync_preamble(DEF_SYNC_CNT, 2);
        foreach (w1[i]) run_h(w1[i]);
        exp_word.push_back(12'hAAA);
        push_error();
        foreach (w2[i]) run_h(w2[i]);
        exp_word.push_back(12'hDD5);
        foreach (pw[i]) run_h(pw[i]);
        run_h(40);
        wait_fe(1, 20000);
        repeat (5) @(negedge SCLOCK);
        check("frame1_idle_inactive", FRAME_ACTIVE, 0);

        // Frame 2: short sync with odd-length runs, then disable mid-decode
        CFG_SYNC_CNT = SYNC_W'(10);
        sync_preamble(10, 3);
        repeat (8) run_h(10);
        wait_active(2000);
        repeat (12) @(negedge SCLOCK);
        ENABLE = 1'b0;
        @(negedge SCLOCK);
        check("disable_frame_active", FRAME_ACTIVE, 0);
        check("disable_word_valid", WORD_VALID, 0);
        check("disable_word_data", WORD_DATA, 0);
        check("disable_bit_error", BIT_ERROR, 0);
        check("disable_err_cnt_held", ERR_CNT, 1);
        line_q.delete();
        cur_level = 1'b0;
        repeat (40) @(negedge SCLOCK);
        check("disabled_stays_idle", FRAME_ACTIVE, 0);
        ENABLE = 1'b1;
        repeat (5) @(negedge SCLOCK);

        // Frame 3: drive the error counter past saturation
        sync_preamble(10, 2);
        repeat ((1 << ERR_W) + 3) begin
            err_model = (err_model == '1) ? err_model : err_model + ERR_W'(1);
            exp_err.push_back(err_model);
            run_h(2);
            run_h(10);
        end
        run_h(4);
        run_h(40);
        wait_fe(2, 20000);
        repeat (5) @(negedge SCLOCK);

        check("err_cnt_saturated", ERR_CNT, {ERR_W{1'b1}});
        check("frame_start_count", fs_cnt, 3);
        check("frame_end_count", fe_cnt, 2);
        check("word_count", word_cnt, 2);
        check("words_pending", exp_word.size(), 0);
        check("errors_pending", exp_err.size(), 0);
        check("bit_error_count", err_seen, (1 << ERR_W) + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
